// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// tiny_proc_pkg
// Shared constants for the tiny processor: datapath/instruction widths,
// instruction memory depth, PC (imem address) width and the state encoding
// of the imem loader FSM.
// No ports (package).
// ---------------------------------------------------------------------------
package tiny_proc_pkg;

  localparam int DATAPATH_W = 8;
  localparam int INST_W     = 8;
  localparam int IMEM_SZ    = 16;
  localparam int PC_W       = $clog2(IMEM_SZ);

  // Loader FSM encoding, kept as plain constants so older tools and
  // hand-written probes can compare against fixed bit patterns.
  typedef logic [1:0] ldr_state_t;

  localparam ldr_state_t ST_IDLE  = 2'd0;
  localparam ldr_state_t ST_RECV  = 2'd1;
  localparam ldr_state_t ST_CHECK = 2'd2;
  localparam ldr_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/imem_loader_sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Brings one asynchronous level into the clk domain through a SYNC_STAGES
// flop chain and produces registered one-cycle rising/falling edge pulses.
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   async_i : asynchronous input level
//   rise_o  : one-cycle pulse after a synchronized 0->1 transition
//   fall_o  : one-cycle pulse after a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  // Edge pulses are registered so the loader sees a clean single-cycle
  // event; this adds one cycle on top of the synchronizer depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Writer side of the instruction memory. Receives a IMEM_SZ-byte program
// from the host (byte per strobe rising edge inside a load_en window),
// writes each byte to imem, stalls the core while loading and checks a
// trailing XOR checksum byte.
// Ports:
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   load_en   : async host load window level
//   strobe    : async host byte strobe, rising edge = data_in valid
//   data_in   : host byte
//   wr_en     : one-cycle imem write pulse
//   wr_addr   : imem write address
//   wr_data   : imem write data
//   core_hold : stall/reset request to the core
//   busy      : loader in RECV or CHECK
//   done      : full image plus checksum received
//   csum_err  : checksum mismatch or aborted load (sticky until next load)
//   count     : bytes accepted in current load, checksum byte included
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int IMEM_SZ     = tiny_proc_pkg::IMEM_SZ,
  parameter int ADDR_W      = tiny_proc_pkg::PC_W,
  parameter int DATA_W      = tiny_proc_pkg::INST_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              strobe,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              csum_err,
  output logic [ADDR_W:0]   count
);

  import tiny_proc_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_SZ - 1);

  logic load_rise;
  logic load_fall;
  logic strb_rise;
  logic strb_fall_unused;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (load_en),
    .rise_o  (load_rise),
    .fall_o  (load_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_strb_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (strobe),
    .rise_o  (strb_rise),
    .fall_o  (strb_fall_unused)
  );

  ldr_state_t        state_q,   state_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] csum_q,    csum_d;
  logic [ADDR_W:0]   count_q,   count_d;
  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              hold_q,    hold_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              err_q,     err_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    csum_d    = csum_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        // A strobe edge coinciding with the load start is deliberately dropped.
        if (load_rise) begin
          state_d = ST_RECV;
          addr_d  = '0;
          csum_d  = '0;
          count_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end

      ST_RECV, ST_CHECK: begin
        // Abort has priority over any byte arriving in the same cycle.
        if (load_fall) begin
          state_d = ST_IDLE;
          hold_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          err_d   = 1'b1;
        end else if (strb_rise) begin
          count_d = count_q + 1'b1;
          if (state_q == ST_RECV) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = data_in;
            csum_d    = csum_q ^ data_in;
            // Address parks on the last word instead of wrapping.
            if (addr_q == LAST_ADDR) begin
              state_d = ST_CHECK;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end else begin
            err_d   = (data_in != csum_q);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // Core stays held until the host closes the load window.
        if (load_fall) begin
          state_d = ST_IDLE;
          hold_d  = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      csum_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      csum_q    <= csum_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign core_hold = hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign csum_err  = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader. A host-level model tracks the load
// protocol (phase, byte count, running XOR, expected imem writes); a monitor
// checks every write pulse against the expected-write queue.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_en = 1'b0;
  logic              strobe = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              csum_err;
  logic [ADDR_W:0]   count;

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .strobe    (strobe),
    .data_in   (data_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .csum_err  (csum_err),
    .count     (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Host-level model
  typedef enum int {P_IDLE, P_RECV, P_CHECK, P_DONE} phase_t;
  phase_t      m_phase = P_IDLE;
  int          m_count = 0;
  int          m_addr  = 0;
  logic [7:0]  m_csum  = 8'h00;
  logic        m_done  = 1'b0;
  logic        m_err   = 1'b0;
  logic [11:0] exp_q[$];

  int n_wr   = 0;
  int wr_cyc = -1;
  logic wr_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      n_wr++;
      wr_cyc = cyc;
      checks++;
      if (wr_prev) begin
        errors++;
        $display("FAIL wr_pulse_width: wr_en high on consecutive cycles at cyc %0d", cyc);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%02h with no write expected", wr_addr, wr_data);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} != e) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%02h expected addr=%0d data=%02h",
                   wr_addr, wr_data, e[11:8], e[7:0]);
        end else begin
          $display("write addr=%0d data=%02h ok", wr_addr, wr_data);
        end
      end
    end
    wr_prev = rst_n & wr_en;
  end

  task automatic model_byte(input logic [7:0] b);
    case (m_phase)
      P_RECV: begin
        exp_q.push_back({4'(m_addr), b});
        m_csum = m_csum ^ b;
        m_count++;
        if (m_count == 16) m_phase = P_CHECK;
        else m_addr++;
      end
      P_CHECK: begin
        m_count++;
        m_err  = (b != m_csum);
        m_done = 1'b1;
        m_phase = P_DONE;
      end
      default: ;
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk) data_in = b;
    @(negedge clk) strobe = 1'b1;
    model_byte(b);
    repeat (3) @(negedge clk);
    strobe = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic load_start();
    @(negedge clk) load_en = 1'b1;
    if (m_phase == P_IDLE) begin
      m_phase = P_RECV; m_count = 0; m_addr = 0; m_csum = 8'h00;
      m_done = 1'b0; m_err = 1'b0;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic load_stop();
    @(negedge clk) load_en = 1'b0;
    if (m_phase == P_RECV || m_phase == P_CHECK) begin
      m_err = 1'b1; m_done = 1'b0;
    end
    m_phase = P_IDLE;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    @(posedge clk); #2;
    $display("status %s: count=%0d done=%0b err=%0b hold=%0b busy=%0b", tag, count, done, csum_err, core_hold, busy);
    chk({tag, ".count"},     int'(count),     m_count);
    chk({tag, ".done"},      int'(done),      int'(m_done));
    chk({tag, ".csum_err"},  int'(csum_err),  int'(m_err));
    chk({tag, ".core_hold"}, int'(core_hold), int'(m_phase != P_IDLE));
    chk({tag, ".busy"},      int'(busy),      int'(m_phase == P_RECV || m_phase == P_CHECK));
    chk({tag, ".pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".wr_en"},     int'(wr_en),     0);
    chk({tag, ".wr_addr"},   int'(wr_addr),   0);
    chk({tag, ".wr_data"},   int'(wr_data),   0);
    chk({tag, ".core_hold"}, int'(core_hold), 0);
    chk({tag, ".busy"},      int'(busy),      0);
    chk({tag, ".done"},      int'(done),      0);
    chk({tag, ".csum_err"},  int'(csum_err),  0);
    chk({tag, ".count"},     int'(count),     0);
  endtask

  logic [7:0] prog [16] = '{8'h59, 8'h0F, 8'h19, 8'h1F, 8'h1E, 8'h05, 8'h1F, 8'h0E,
                            8'hF8, 8'h0F, 8'h43, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    int w0;
    int t0;

    // Power-up with reset held
    repeat (3) @(negedge clk);
    #2;
    check_all_zero("por");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Async reset in the middle of a load
    load_start();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    @(negedge clk); #2;
    rst_n = 1'b0; load_en = 1'b0;
    #1;
    check_all_zero("mid_load_reset");
    m_phase = P_IDLE; m_count = 0; m_addr = 0; m_csum = 8'h00;
    m_done = 1'b0; m_err = 1'b0; exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Good load
    w0 = n_wr;
    load_start();
    check_status("good_start");
    for (int i = 0; i < 16; i++) send_byte(prog[i]);
    check_status("good_16");
    send_byte(8'hEE);
    check_status("good_csum");
    chk("good.literal_count", int'(count), 17);
    chk("good.literal_done", int'(done), 1);
    chk("good.literal_err", int'(csum_err), 0);
    chk("good.writes", n_wr - w0, 16);
    load_stop();
    check_status("good_release");

    // Bad checksum
    w0 = n_wr;
    load_start();
    check_status("bad_start");
    for (int i = 0; i < 16; i++) send_byte(prog[i]);
    send_byte(8'hEF);
    check_status("bad_csum");
    chk("bad.literal_err", int'(csum_err), 1);
    chk("bad.literal_done", int'(done), 1);
    chk("bad.writes", n_wr - w0, 16);
    load_stop();

    // Abort after five bytes
    w0 = n_wr;
    load_start();
    for (int i = 1; i <= 5; i++) send_byte(8'(i * 8'h11));
    load_stop();
    check_status("abort");
    chk("abort.literal_count", int'(count), 5);
    chk("abort.literal_err", int'(csum_err), 1);
    chk("abort.literal_hold", int'(core_hold), 0);
    chk("abort.writes", n_wr - w0, 5);

    // Strobes outside a load window are ignored
    w0 = n_wr;
    send_byte(8'h77); send_byte(8'h78);
    chk("idle_strobe.writes", n_wr - w0, 0);
    check_status("idle_strobe");

    // Strobe held high: one write, fixed latency
    load_start();
    w0 = n_wr;
    @(negedge clk) data_in = 8'h6A;
    @(negedge clk) strobe = 1'b1;
    t0 = cyc;
    model_byte(8'h6A);
    repeat (20) @(negedge clk);
    strobe = 1'b0;
    repeat (6) @(negedge clk);
    chk("held.writes", n_wr - w0, 1);
    chk("held.latency_edges", wr_cyc - t0, 4);
    send_byte(8'h21);
    check_status("held_next");
    load_stop();

    // load_en and strobe rise together: load start only
    w0 = n_wr;
    @(negedge clk);
    load_en = 1'b1; strobe = 1'b1; data_in = 8'hA5;
    m_phase = P_RECV; m_count = 0; m_addr = 0; m_csum = 8'h00;
    m_done = 1'b0; m_err = 1'b0;
    repeat (6) @(negedge clk);
    strobe = 1'b0;
    repeat (6) @(negedge clk);
    check_status("collision");
    chk("collision.writes", n_wr - w0, 0);
    send_byte(8'h3C);
    check_status("collision_next");
    load_stop();
    check_status("collision_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction memory. It receives a 16-instruction program byte-by-byte from the host over the bidirectional pins, using a level load-enable and a strobe, both asynchronous. It writes each byte into the core's imem and holds the core stalled while loading. It checks a trailing XOR checksum byte and reports done/error. It sits beside the processor core in the tiny_processor top; the top gates the core's pc/acc reset with core_hold.

Parameters:
IMEM_SZ, 16, number of instruction words to load
ADDR_W, 4, imem address width (clog2 of IMEM_SZ)
DATA_W, 8, instruction/byte width
SYNC_STAGES, 2, flop depth of the input synchronizers (min 2)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
load_en  input  1  host load window (ui_in[7]), asynchronous level
strobe  input  1  host byte strobe (ui_in[6]), asynchronous; a rising edge means data_in is valid
data_in  input  DATA_W  host byte (uio_in)
wr_en  output  1  one-cycle imem write pulse
wr_addr  output  ADDR_W  imem write address
wr_data  output  DATA_W  imem write data
core_hold  output  1  stall/reset request to the core
busy  output  1  in RECV or CHECK
done  output  1  full image plus checksum received
csum_err  output  1  checksum mismatch or aborted load (sticky until next load)
count  output  ADDR_W+1  bytes accepted in current load, including the checksum byte (0..IMEM_SZ+1)

Behaviour:
- Reset (async assert, sync release via rst_n): state=IDLE; all outputs 0; addr=0; csum=0.
- load_en and strobe each pass through a SYNC_STAGES flop synchronizer, then a rising-edge detector (previous-value register).
- data_in is sampled in the cycle the synchronized strobe edge is detected. The host holds data_in stable from at least 1 cycle before strobe rises until strobe falls.
- Latency: wr_en asserts SYNC_STAGES+1 cycles after the first clk edge that samples strobe high (3 with default). wr_en is high for exactly 1 cycle. wr_addr/wr_data are registered and valid in the same cycle.
- A strobe held high produces exactly one write. The next byte requires strobe to fall and rise again.
- FSM states:
  - IDLE: core_hold=0. A load_en rising edge moves to RECV and, in the same cycle, sets addr=0, csum=0, count=0, done=0, csum_err=0, core_hold=1, busy=1. Strobe edges are ignored.
  - RECV: on each strobe edge, write the byte at addr; csum ^= byte; addr++ and count++. After the write to addr IMEM_SZ-1, go to CHECK. addr does not wrap past IMEM_SZ-1 in use.
  - CHECK: on the next strobe edge, count++ and csum_err <= (byte != csum). Move to DONE with done=1 and busy=0. No write occurs.
  - DONE: core_hold stays 1 and strobe edges are ignored. A load_en falling edge moves to IDLE with core_hold=0. done and csum_err hold their values.
- Abort: load_en falls in RECV or CHECK → IDLE with core_hold=0, busy=0, done=0, csum_err=1. count holds. Bytes already written stay in imem.
- Simultaneous events: load_en rise and strobe edge in the same cycle → only the load start is taken. load_en fall and strobe edge in the same cycle in RECV/CHECK → abort wins and no write occurs.
- Async reset mid-load: immediate return to reset values; core_hold drops.
- In the top, core pc/acc reset = ~rst_n | core_hold, so the core restarts from pc=0 when core_hold falls.

Decomposition:
- Shared package tiny_proc_pkg holds DATAPATH_W, INST_W, IMEM_SZ, the PC/address width, and the loader state encoding (IDLE, RECV, CHECK, DONE).
- One sub-module, sync_edge_det: a SYNC_STAGES synchronizer plus rising/falling edge outputs. It is instantiated twice, for load_en and strobe.
- The FSM, address counter and checksum stay in imem_loader.

Test Plan:
- Reset: assert rst_n=0 mid-load (after 3 bytes) → all outputs 0 asynchronously, state IDLE; with rst_n held 0 from power-up, outputs are also 0.
- Good load: load_en=1; strobe bytes 59 0F 19 1F 1E 05 1F 0E F8 0F 43 00 00 00 00 00, then checksum EE → 16 wr_en pulses at addr 0..15 with matching data, count=17, done=1, csum_err=0; core_hold stays 1 until load_en=0, then falls.
- Bad checksum: same 16 bytes, then checksum EF → done=1, csum_err=1, 16 writes only.
- Abort: load_en=1, 5 bytes (0x11..0x55), load_en=0 → 5 writes at addr 0..4, then IDLE, core_hold=0, done=0, csum_err=1, count=5.
- Idle/strobe rules: strobe pulses with load_en=0 → no wr_en. Strobe held high for 20 cycles in RECV → exactly one wr_en, asserted 3 clk edges after the first edge sampling strobe high.
- Collision: load_en and strobe rise in the same cycle → RECV entered, count=0, no write; a later strobe writes addr 0.
